fetch_hazard_ctrl: RTL and testbench
====================================

Name: fetch_hazard_ctrl

Overview:
Sequencing controller for the instruction-fetch stage and the IF/ID pipeline register.
- Drives PC write-enable, the branch/jump select lines and the IF/ID write/flush controls.
- Detects load-use hazards, applies ID-stage redirects and inserts wait states for slow instruction memory.
- Holds the fetch path idle after reset, stops fetch on halt, and counts lost cycles.

Parameters:
IMEM_WAIT, 0, extra cycles each fetch takes before the instruction is valid (0 = single-cycle memory).
BOOT_CYCLES, 2, cycles the fetch path is held idle after reset release (minimum 1).
REG_ADDR_W, 5, register-specifier width.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset.
id_rs  in  REG_ADDR_W  rs field of the instruction in ID.
id_rt  in  REG_ADDR_W  rt field of the instruction in ID.
id_uses_rt  in  1  ID instruction reads rt as a source.
ex_mem_read  in  1  EX instruction is a load.
ex_rt  in  REG_ADDR_W  destination of the EX load.
id_branch_taken  in  1  branch in ID resolved taken.
id_jump  in  1  jump in ID.
halt  in  1  halt instruction in ID.
pc_write  out  1  PC register enable.
pc_src  out  1  1 = select branch address.
is_j  out  1  1 = select jump address; overrides pc_src.
ifid_write  out  1  IF/ID register enable.
ifid_flush  out  1  IF/ID loads NOP when written.
idex_bubble  out  1  ID/EX loads control-zero bubble.
fetch_valid  out  1  the instruction at the memory output is accepted this cycle.
lost_cycles  out  16  saturating count of stall, wait and bubble cycles.

Behaviour:
- Outputs are combinational from state and current inputs (Mealy). All state is reset asynchronously while rst = 0.
- States: BOOT, WAIT, ISSUE, HALT.
- Reset values: state BOOT, boot and wait counters 0, lost_cycles 0.
- Output values while in reset (BOOT): pc_write 0, pc_src 0, is_j 0, ifid_write 1, ifid_flush 1, idex_bubble 0, fetch_valid 0.
- hazard = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
- redirect = id_branch_taken | id_jump, qualified by ~hazard. Branch operands are not ready during a hazard, so hazard has priority over redirect.
- BOOT:
  - Outputs as at reset.
  - Counts BOOT_CYCLES cycles, then goes to WAIT (wait counter loaded with IMEM_WAIT) if IMEM_WAIT > 0, else to ISSUE.
- ISSUE, with hazard:
  - pc_write 0, ifid_write 0, idex_bubble 1; remain in ISSUE.
  - halt and redirect are ignored this cycle.
- ISSUE, no hazard, halt = 1:
  - pc_write 0, ifid_write 1, ifid_flush 1; next state HALT.
- ISSUE, no hazard, no halt:
  - pc_write 1, ifid_write 1, fetch_valid 1.
  - If redirect: is_j = id_jump, pc_src = id_branch_taken & ~id_jump, ifid_flush 1.
  - Next state: WAIT with counter = IMEM_WAIT if IMEM_WAIT > 0, else ISSUE.
- WAIT:
  - Counter decrements each cycle; at counter == 1 the next state is ISSUE.
  - Without hazard: ifid_write 1, ifid_flush 1, so a NOP enters ID while the older instruction advances.
  - With hazard: ifid_write 0, idex_bubble 1.
  - A redirect in WAIT applies immediately: pc_write 1 with the select lines as in ISSUE, ifid_flush 1, counter reloaded with IMEM_WAIT. The in-flight fetch is abandoned.
- Simultaneous branch and jump: the jump wins.
- HALT:
  - Sticky until reset. pc_write 0, ifid_write 1, ifid_flush 1, idex_bubble 0.
- lost_cycles:
  - Increments by 1 each cycle the state is WAIT or idex_bubble = 1 (BOOT and HALT not counted).
  - Saturates at 16'hFFFF.
- Reset asserted mid-operation: immediate return to BOOT; the counter clears.

Decomposition:
- Shared package: state encoding (2-bit: BOOT, WAIT, ISSUE, HALT), NOP instruction constant, register-zero index.
- Sub-module: load_use_detect, a combinational hazard comparator (id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt -> hazard). It is reused by the forwarding unit.

Test Plan:
- Reset with BOOT_CYCLES = 2, IMEM_WAIT = 0 -> pc_write 0 for 2 cycles after release, then 1 every cycle; lost_cycles stays 0.
- ex_mem_read = 1, ex_rt = 8, id_rs = 8 -> one cycle with pc_write 0, ifid_write 0, idex_bubble 1; lost_cycles = 1. Same stimulus with ex_rt = 0 -> no stall.
- id_branch_taken = 1 with no hazard -> pc_src 1, is_j 0, pc_write 1, ifid_flush 1. Same with id_jump = 1 also asserted -> is_j 1, pc_src 0.
- IMEM_WAIT = 2, no hazards -> pc_write pattern 1,0,0,1,0,0; fetch_valid pattern matches; lost_cycles +2 per fetch.
- IMEM_WAIT = 2, id_jump asserted in the first WAIT cycle -> is_j 1, pc_write 1 that cycle, then 2 full wait cycles before the next ISSUE.
- halt = 1 in ISSUE -> HALT; pc_write stays 0 indefinitely. rst = 0 pulse -> BOOT and lost_cycles = 0.

Source files
------------

// File: rtl/fetch_hazard_ctrl_pkg.sv
// Shared definitions for the fetch-stage sequencing controller and its hazard comparator.
package fetch_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int unsigned REG_ZERO  = 0;

endpackage

// File: rtl/fetch_hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator; also shared with the forwarding unit.
module load_use_detect
  import fetch_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  hazard
);

  // A load into the zero register never produces a value worth waiting for.
  assign hazard = ex_mem_read
                & (ex_rt != REG_ADDR_W'(REG_ZERO))
                & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Fetch / IF-ID sequencing: boot hold-off, load-use stalls, ID redirects,
// instruction-memory wait states, halt, and a saturating lost-cycle counter.
module fetch_hazard_ctrl
  import fetch_hazard_ctrl_pkg::*;
#(
  parameter int IMEM_WAIT   = 0,
  parameter int BOOT_CYCLES = 2,
  parameter int REG_ADDR_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  id_branch_taken,
  input  logic                  id_jump,
  input  logic                  halt,
  output logic                  pc_write,
  output logic                  pc_src,
  output logic                  is_j,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  fetch_valid,
  output logic [15:0]           lost_cycles
);

  localparam int WAIT_W = (IMEM_WAIT < 1) ? 1 : $clog2(IMEM_WAIT + 1);
  localparam int BOOT_W = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(IMEM_WAIT);
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
  localparam fetch_state_t ST_AFTER_FETCH = (IMEM_WAIT > 0) ? ST_WAIT : ST_ISSUE;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  fetch_state_t      state_q, state_d;
  logic [BOOT_W-1:0] boot_q, boot_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              hazard;
  logic              redirect;

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .hazard      (hazard)
  );

  // Branch operands are stale during a load-use hazard, so the redirect waits.
  assign redirect = (id_branch_taken | id_jump) & ~hazard;

  always_comb begin
    state_d     = state_q;
    boot_d      = boot_q;
    wait_d      = wait_q;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    is_j        = 1'b0;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b1;
    idex_bubble = 1'b0;
    fetch_valid = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        if (boot_q == BOOT_LAST) begin
          boot_d  = '0;
          wait_d  = WAIT_LOAD;
          state_d = ST_AFTER_FETCH;
        end else begin
          boot_d = boot_q + 1'b1;
        end
      end

      ST_ISSUE: begin
        if (hazard) begin
          ifid_write  = 1'b0;
          ifid_flush  = 1'b0;
          idex_bubble = 1'b1;
        end else if (halt) begin
          state_d = ST_HALT;
        end else begin
          pc_write    = 1'b1;
          fetch_valid = 1'b1;
          ifid_flush  = redirect;
          is_j        = id_jump;
          pc_src      = id_branch_taken & ~id_jump;
          wait_d      = WAIT_LOAD;
          state_d     = ST_AFTER_FETCH;
        end
      end

      ST_WAIT: begin
        if (hazard) begin
          ifid_write  = 1'b0;
          ifid_flush  = 1'b0;
          idex_bubble = 1'b1;
        end
        // A redirect abandons the in-flight fetch and restarts the wait.
        if (redirect) begin
          pc_write = 1'b1;
          is_j     = id_jump;
          pc_src   = id_branch_taken & ~id_jump;
          wait_d   = WAIT_LOAD;
        end else begin
          wait_d = wait_q - 1'b1;
          if (wait_q == WAIT_W'(1)) state_d = ST_ISSUE;
        end
      end

      ST_HALT: ;

      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_BOOT;
      boot_q      <= '0;
      wait_q      <= '0;
      lost_cycles <= 16'd0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      wait_q  <= wait_d;
      if ((state_q == ST_WAIT) || idex_bubble) lost_cycles <= sat_inc(lost_cycles);
    end
  end

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Directed bench: single-cycle memory instance and a two-wait-state instance share stimulus.
module tb_fetch_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0;
  logic       id_branch_taken = 1'b0, id_jump = 1'b0, halt = 1'b0;

  logic        a_pc_write, a_pc_src, a_is_j, a_ifid_write, a_ifid_flush, a_idex_bubble, a_fetch_valid;
  logic [15:0] a_lost;
  logic        b_pc_write, b_pc_src, b_is_j, b_ifid_write, b_ifid_flush, b_idex_bubble, b_fetch_valid;
  logic [15:0] b_lost;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_hazard_ctrl #(.IMEM_WAIT(0), .BOOT_CYCLES(2), .REG_ADDR_W(5)) dut_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_branch_taken(id_branch_taken),
    .id_jump(id_jump), .halt(halt), .pc_write(a_pc_write), .pc_src(a_pc_src),
    .is_j(a_is_j), .ifid_write(a_ifid_write), .ifid_flush(a_ifid_flush),
    .idex_bubble(a_idex_bubble), .fetch_valid(a_fetch_valid), .lost_cycles(a_lost)
  );

  fetch_hazard_ctrl #(.IMEM_WAIT(2), .BOOT_CYCLES(2), .REG_ADDR_W(5)) dut_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_branch_taken(id_branch_taken),
    .id_jump(id_jump), .halt(halt), .pc_write(b_pc_write), .pc_src(b_pc_src),
    .is_j(b_is_j), .ifid_write(b_ifid_write), .ifid_flush(b_ifid_flush),
    .idex_bubble(b_idex_bubble), .fetch_valid(b_fetch_valid), .lost_cycles(b_lost)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed outputs: {pc_write, pc_src, is_j, ifid_write, ifid_flush, idex_bubble, fetch_valid}
  task automatic chk_a(input string tag, input logic [6:0] exp);
    chk(tag, {9'd0, a_pc_write, a_pc_src, a_is_j, a_ifid_write, a_ifid_flush,
              a_idex_bubble, a_fetch_valid}, {9'd0, exp});
  endtask

  task automatic chk_b(input string tag, input logic [6:0] exp);
    chk(tag, {9'd0, b_pc_write, b_pc_src, b_is_j, b_ifid_write, b_ifid_flush,
              b_idex_bubble, b_fetch_valid}, {9'd0, exp});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk_a("reset_outs", 7'b0001100);
    chk("reset_lost", a_lost, 16'd0);
    next_cycle();
    rst = 1'b1;

    // Boot hold-off, then continuous fetch
    @(negedge clk); chk_a("boot0", 7'b0001100);
    next_cycle();
    @(negedge clk); chk_a("boot1", 7'b0001100);
    next_cycle();
    @(negedge clk); chk_a("issue0", 7'b1001001);
    next_cycle();
    @(negedge clk); chk_a("issue1", 7'b1001001);
    chk("lost_after_boot", a_lost, 16'd0);
    next_cycle();

    // Load-use on rs
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    @(negedge clk); chk_a("hazard_rs", 7'b0000010);
    next_cycle();
    ex_mem_read = 1'b0;
    @(negedge clk); chk_a("after_hazard", 7'b1001001);
    chk("lost_one_bubble", a_lost, 16'd1);
    next_cycle();

    // Load into register zero never stalls
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    @(negedge clk); chk_a("zero_reg_no_stall", 7'b1001001);
    next_cycle();

    // Load-use on rt, only when rt is a source
    ex_rt = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b1;
    @(negedge clk); chk_a("hazard_rt", 7'b0000010);
    next_cycle();
    id_uses_rt = 1'b0;
    @(negedge clk); chk_a("rt_not_source", 7'b1001001);
    chk("lost_two_bubbles", a_lost, 16'd2);
    next_cycle();

    // Hazard beats a taken branch
    id_uses_rt = 1'b1; id_branch_taken = 1'b1;
    @(negedge clk); chk_a("hazard_over_branch", 7'b0000010);
    next_cycle();
    ex_mem_read = 1'b0; id_uses_rt = 1'b0;
    @(negedge clk); chk_a("branch_taken", 7'b1101101);
    chk("lost_three", a_lost, 16'd3);
    next_cycle();
    id_jump = 1'b1;
    @(negedge clk); chk_a("jump_over_branch", 7'b1011101);
    next_cycle();
    id_branch_taken = 1'b0;
    @(negedge clk); chk_a("jump_only", 7'b1011101);
    next_cycle();
    id_jump = 1'b0;

    // Halt is sticky
    halt = 1'b1;
    @(negedge clk); chk_a("halt_issue", 7'b0001100);
    next_cycle();
    halt = 1'b0;
    @(negedge clk); chk_a("halted0", 7'b0001100);
    next_cycle();
    id_branch_taken = 1'b1;
    @(negedge clk); chk_a("halted_branch", 7'b0001100);
    next_cycle();
    id_branch_taken = 1'b0;
    @(negedge clk); chk("lost_in_halt", a_lost, 16'd3);

    // Asynchronous reset pulse mid-operation
    #1 rst = 1'b0;
    #1;
    chk("rst_clears_lost_a", a_lost, 16'd0);
    chk("rst_clears_lost_b", b_lost, 16'd0);
    chk_a("rst_boot_outs", 7'b0001100);
    next_cycle();
    rst = 1'b1;

    // Two-wait-state memory: boot, then W W I W W I
    @(negedge clk); chk_b("b_boot0", 7'b0001100);
    next_cycle();
    @(negedge clk); chk_b("b_boot1", 7'b0001100);
    next_cycle();
    @(negedge clk); chk_b("b_wait0", 7'b0001100);
    next_cycle();
    @(negedge clk); chk_b("b_wait1", 7'b0001100);
    next_cycle();
    @(negedge clk); chk_b("b_issue0", 7'b1001001);
    chk("b_lost_first_fetch", b_lost, 16'd2);
    next_cycle();
    @(negedge clk); chk_b("b_wait2", 7'b0001100);
    next_cycle();
    @(negedge clk); chk_b("b_wait3", 7'b0001100);
    next_cycle();
    @(negedge clk); chk_b("b_issue1", 7'b1001001);
    chk("b_lost_second_fetch", b_lost, 16'd4);
    next_cycle();

    // Jump in the first wait cycle restarts the wait
    id_jump = 1'b1;
    @(negedge clk); chk_b("b_jump_in_wait", 7'b1011100);
    next_cycle();
    id_jump = 1'b0;
    @(negedge clk); chk_b("b_wait_after_jump0", 7'b0001100);
    next_cycle();
    @(negedge clk); chk_b("b_wait_after_jump1", 7'b0001100);
    next_cycle();
    @(negedge clk); chk_b("b_issue_after_jump", 7'b1001001);
    chk("b_lost_after_jump", b_lost, 16'd7);
    next_cycle();

    // Hazard during a wait cycle bubbles and still counts once
    ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
    @(negedge clk); chk_b("b_hazard_in_wait", 7'b0000010);
    next_cycle();
    ex_mem_read = 1'b0;
    @(negedge clk); chk_b("b_wait_after_hazard", 7'b0001100);
    chk("b_lost_hazard_wait", b_lost, 16'd8);
    next_cycle();
    @(negedge clk); chk_b("b_issue_after_hazard", 7'b1001001);
    chk("b_lost_final", b_lost, 16'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
